// File: rtl/spi_frame_decoder.sv
// Passive SPI decoder for both data lanes: synchronises the raw bus pins, detects
// the mode-dependent sample edge and reports complete words, truncated frames and a word count.
module spi_frame_decoder #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int BC_W        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             mosi,
  input  logic             miso,
  input  logic             csn,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             lsb_first,
  input  logic             detect_only,
  input  logic             clr,
  output logic [WIDTH-1:0] mosi_data,
  output logic [WIDTH-1:0] miso_data,
  output logic             valid,
  output logic             detected,
  output logic             partial,
  output logic [BC_W-1:0]  partial_bits,
  output logic [CNT_W-1:0] word_cnt,
  output logic             busy
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_reg, mosi_sync_reg, miso_sync_reg, csn_sync_reg;
  logic s_sclk, s_mosi, s_miso, s_csn;

  state_t           state_reg, state_next;
  logic             prev_sclk_reg, prev_csn_reg;
  logic             cpol_reg, cpol_next;
  logic             cpha_reg, cpha_next;
  logic             lsb_reg, lsb_next;
  logic [BC_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [WIDTH-1:0] mosi_sh_reg, mosi_sh_next;
  logic [WIDTH-1:0] miso_sh_reg, miso_sh_next;
  logic [WIDTH-1:0] mosi_data_reg, mosi_data_next;
  logic [WIDTH-1:0] miso_data_reg, miso_data_next;
  logic             valid_reg, valid_next;
  logic             detected_reg, detected_next;
  logic             partial_reg, partial_next;
  logic [BC_W-1:0]  partial_bits_reg, partial_bits_next;
  logic [CNT_W-1:0] word_cnt_reg, word_cnt_next;

  logic             sample_edge, csn_fall, complete, last_bit;
  logic [WIDTH-1:0] mosi_shifted, miso_shifted;

  assign s_sclk = sclk_sync_reg[SYNC_STAGES-1];
  assign s_mosi = mosi_sync_reg[SYNC_STAGES-1];
  assign s_miso = miso_sync_reg[SYNC_STAGES-1];
  assign s_csn  = csn_sync_reg[SYNC_STAGES-1];

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
  assign sample_edge = (cpol_reg ^ cpha_reg) ? (~s_sclk & prev_sclk_reg)
                                             : (s_sclk & ~prev_sclk_reg);
  assign csn_fall    = prev_csn_reg & ~s_csn;
  assign last_bit    = (bit_cnt_reg == BC_W'(WIDTH - 1));

  assign mosi_shifted = lsb_reg ? {s_mosi, mosi_sh_reg[WIDTH-1:1]}
                                : {mosi_sh_reg[WIDTH-2:0], s_mosi};
  assign miso_shifted = lsb_reg ? {s_miso, miso_sh_reg[WIDTH-1:1]}
                                : {miso_sh_reg[WIDTH-2:0], s_miso};

  always_comb begin
    state_next        = state_reg;
    cpol_next         = cpol_reg;
    cpha_next         = cpha_reg;
    lsb_next          = lsb_reg;
    bit_cnt_next      = bit_cnt_reg;
    mosi_sh_next      = mosi_sh_reg;
    miso_sh_next      = miso_sh_reg;
    mosi_data_next    = mosi_data_reg;
    miso_data_next    = miso_data_reg;
    valid_next        = 1'b0;
    detected_next     = 1'b0;
    partial_next      = 1'b0;
    partial_bits_next = partial_bits_reg;
    complete          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (csn_fall) begin
          cpol_next    = cpol;
          cpha_next    = cpha;
          lsb_next     = lsb_first;
          bit_cnt_next = '0;
          mosi_sh_next = '0;
          miso_sh_next = '0;
          state_next   = ACTIVE;
        end
      end
      ACTIVE: begin
        // Chip-select release beats any sample edge seen in the same cycle.
        if (s_csn) begin
          state_next = IDLE;
          if (bit_cnt_reg != '0) begin
            partial_next      = 1'b1;
            partial_bits_next = bit_cnt_reg;
          end
        end else if (sample_edge) begin
          mosi_sh_next = mosi_shifted;
          miso_sh_next = miso_shifted;
          if (last_bit) begin
            bit_cnt_next  = '0;
            detected_next = 1'b1;
            complete      = 1'b1;
            if (!detect_only) begin
              valid_next     = 1'b1;
              mosi_data_next = mosi_shifted;
              miso_data_next = miso_shifted;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + BC_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    word_cnt_next = word_cnt_reg;
    if (clr) begin
      word_cnt_next = '0;
    end else if (complete && !(&word_cnt_reg)) begin
      word_cnt_next = word_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_reg    <= '0;
      mosi_sync_reg    <= '0;
      miso_sync_reg    <= '0;
      csn_sync_reg     <= '1;
      prev_sclk_reg    <= 1'b0;
      prev_csn_reg     <= 1'b1;
      state_reg        <= IDLE;
      cpol_reg         <= 1'b0;
      cpha_reg         <= 1'b0;
      lsb_reg          <= 1'b0;
      bit_cnt_reg      <= '0;
      mosi_sh_reg      <= '0;
      miso_sh_reg      <= '0;
      mosi_data_reg    <= '0;
      miso_data_reg    <= '0;
      valid_reg        <= 1'b0;
      detected_reg     <= 1'b0;
      partial_reg      <= 1'b0;
      partial_bits_reg <= '0;
      word_cnt_reg     <= '0;
    end else begin
      sclk_sync_reg    <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
      mosi_sync_reg    <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
      miso_sync_reg    <= {miso_sync_reg[SYNC_STAGES-2:0], miso};
      csn_sync_reg     <= {csn_sync_reg[SYNC_STAGES-2:0], csn};
      prev_sclk_reg    <= s_sclk;
      prev_csn_reg     <= s_csn;
      state_reg        <= state_next;
      cpol_reg         <= cpol_next;
      cpha_reg         <= cpha_next;
      lsb_reg          <= lsb_next;
      bit_cnt_reg      <= bit_cnt_next;
      mosi_sh_reg      <= mosi_sh_next;
      miso_sh_reg      <= miso_sh_next;
      mosi_data_reg    <= mosi_data_next;
      miso_data_reg    <= miso_data_next;
      valid_reg        <= valid_next;
      detected_reg     <= detected_next;
      partial_reg      <= partial_next;
      partial_bits_reg <= partial_bits_next;
      word_cnt_reg     <= word_cnt_next;
    end
  end

  assign mosi_data    = mosi_data_reg;
  assign miso_data    = miso_data_reg;
  assign valid        = valid_reg;
  assign detected     = detected_reg;
  assign partial      = partial_reg;
  assign partial_bits = partial_bits_reg;
  assign word_cnt     = word_cnt_reg;
  assign busy         = (state_reg == ACTIVE);

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Directed bench for spi_frame_decoder: two instances (8-bit word with 4-bit counter, 12-bit word)
// share the bus lanes; a word-level model built from the bits on the wire is checked every cycle.
module tb_spi_frame_decoder;
  localparam int H = 4;  // sclk phase length in clk cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, sclk, mosi, miso, csn_a, csn_b, cpol, cpha, lsb_first, detect_only, clr;

  logic [7:0]  a_mosi_data, a_miso_data;
  logic        a_valid, a_detected, a_partial, a_busy;
  logic [2:0]  a_partial_bits;
  logic [3:0]  a_word_cnt;
  logic [11:0] b_mosi_data, b_miso_data;
  logic        b_valid, b_detected, b_partial, b_busy;
  logic [3:0]  b_partial_bits;
  logic [15:0] b_word_cnt;

  spi_frame_decoder #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .miso(miso), .csn(csn_a),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .detect_only(detect_only), .clr(clr),
    .mosi_data(a_mosi_data), .miso_data(a_miso_data), .valid(a_valid), .detected(a_detected),
    .partial(a_partial), .partial_bits(a_partial_bits), .word_cnt(a_word_cnt), .busy(a_busy));

  spi_frame_decoder #(.WIDTH(12), .SYNC_STAGES(2), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .miso(miso), .csn(csn_b),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .detect_only(detect_only), .clr(clr),
    .mosi_data(b_mosi_data), .miso_data(b_miso_data), .valid(b_valid), .detected(b_detected),
    .partial(b_partial), .partial_bits(b_partial_bits), .word_cnt(b_word_cnt), .busy(b_busy));

  logic [31:0] o_md[2], o_sd[2], o_pb[2], o_wc[2];
  logic        o_v[2], o_d[2], o_p[2], o_b[2];
  assign o_md[0] = 32'(a_mosi_data);    assign o_md[1] = 32'(b_mosi_data);
  assign o_sd[0] = 32'(a_miso_data);    assign o_sd[1] = 32'(b_miso_data);
  assign o_pb[0] = 32'(a_partial_bits); assign o_pb[1] = 32'(b_partial_bits);
  assign o_wc[0] = 32'(a_word_cnt);     assign o_wc[1] = 32'(b_word_cnt);
  assign o_v[0] = a_valid;    assign o_v[1] = b_valid;
  assign o_d[0] = a_detected; assign o_d[1] = b_detected;
  assign o_p[0] = a_partial;  assign o_p[1] = b_partial;
  assign o_b[0] = a_busy;     assign o_b[1] = b_busy;

  typedef struct {
    logic [31:0] m;
    logic [31:0] s;
    bit          v;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  int          wdt[2]  = '{8, 12};
  int          cmax[2] = '{15, 65535};
  exp_t        exp_q[2][$];
  int          exp_p[2][$];
  logic [31:0] cap_m[2][$];
  logic [31:0] last_m[2], last_s[2], last_pb[2];
  logic [31:0] accm[2], accs[2];
  int          nb[2], mcnt[2];
  bit          cur_cpol, cur_cpha, cur_lsb;
  logic        rst_q;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) rst_q <= rst_n;

  // Single compare process: every cycle, every instance.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_q === 1'b0) begin
        chk("rst_valid", o_v[i], 0);
        chk("rst_detected", o_d[i], 0);
        chk("rst_partial", o_p[i], 0);
        chk("rst_busy", o_b[i], 0);
        chk("rst_mosi", o_md[i], 0);
        chk("rst_miso", o_sd[i], 0);
        chk("rst_pbits", o_pb[i], 0);
        chk("rst_cnt", o_wc[i], 0);
        last_m[i] = '0; last_s[i] = '0; last_pb[i] = '0;
      end else begin
        if (o_d[i]) begin
          if (exp_q[i].size() == 0) begin
            chk("unexpected_detected", 1, 0);
          end else begin
            exp_t e;
            e = exp_q[i].pop_front();
            chk("valid_with_detect", o_v[i], e.v);
            if (e.v) begin
              chk("mosi_word", o_md[i], e.m);
              chk("miso_word", o_sd[i], e.s);
            end
          end
        end else begin
          chk("valid_without_detect", o_v[i], 0);
        end
        if (o_v[i]) begin
          last_m[i] = o_md[i];
          last_s[i] = o_sd[i];
          cap_m[i].push_back(o_md[i]);
        end else begin
          chk("mosi_hold", o_md[i], last_m[i]);
          chk("miso_hold", o_sd[i], last_s[i]);
        end
        if (o_p[i]) begin
          if (exp_p[i].size() == 0) begin
            chk("unexpected_partial", 1, 0);
          end else begin
            chk("partial_bits", o_pb[i], 32'(exp_p[i].pop_front()));
          end
          last_pb[i] = o_pb[i];
        end else begin
          chk("pbits_hold", o_pb[i], last_pb[i]);
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_csn(int i, logic v);
    if (i == 0) csn_a = v; else csn_b = v;
  endtask

  // Model: bit k of a word is the word's MSB-minus-k (MSB-first) or bit k (LSB-first).
  task automatic model_bit(int i, bit bm, bit bs);
    int idx;
    exp_t e;
    idx = cur_lsb ? nb[i] : wdt[i] - 1 - nb[i];
    accm[i][idx] = bm;
    accs[i][idx] = bs;
    nb[i]++;
    if (nb[i] == wdt[i]) begin
      e.m = accm[i]; e.s = accs[i]; e.v = !detect_only;
      exp_q[i].push_back(e);
      if (mcnt[i] < cmax[i]) mcnt[i]++;
      nb[i] = 0; accm[i] = '0; accs[i] = '0;
    end
  endtask

  // clr is timed to land in the cycle the decoder registers the completing sample edge.
  task automatic phase_wait(bit clr_here);
    if (clr_here) begin
      tick(2); clr = 1'b1; tick(1); clr = 1'b0;
      mcnt[0] = 0; mcnt[1] = 0;
      tick(H - 3);
    end else begin
      tick(H);
    end
  endtask

  task automatic send_bit(int i, bit bm, bit bs, bit clr_here);
    if (!cur_cpha) begin
      mosi = bm; miso = bs; tick(H);
      sclk = ~cur_cpol; model_bit(i, bm, bs); phase_wait(clr_here);
      sclk = cur_cpol;
    end else begin
      sclk = ~cur_cpol; mosi = bm; miso = bs; tick(H);
      sclk = cur_cpol; model_bit(i, bm, bs); phase_wait(clr_here);
    end
  endtask

  task automatic send_word(int i, logic [31:0] mv, logic [31:0] sv, int n, bit clr_last);
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = cur_lsb ? k : n - 1 - k;
      send_bit(i, mv[idx], sv[idx], clr_last && (k == n - 1));
    end
  endtask

  // Mode pins are scrambled once the frame is under way; the decoder must ignore them.
  task automatic frame_begin(int i, bit pol, bit pha, bit lsb);
    cpol = pol; cpha = pha; lsb_first = lsb;
    cur_cpol = pol; cur_cpha = pha; cur_lsb = lsb;
    sclk = pol;
    nb[i] = 0; accm[i] = '0; accs[i] = '0;
    tick(4);
    set_csn(i, 1'b0);
    tick(4);
    cpol = ~pol; cpha = ~pha; lsb_first = ~lsb;
    chk("busy_in_frame", o_b[i], 1);
  endtask

  task automatic frame_end(int i);
    tick(H);
    if (nb[i] != 0) exp_p[i].push_back(nb[i]);
    set_csn(i, 1'b1);
    tick(8);
    nb[i] = 0;
  endtask

  task automatic check_end(int i);
    chk("exp_left", 32'(exp_q[i].size()), 0);
    chk("partial_left", 32'(exp_p[i].size()), 0);
    chk("word_cnt_model", o_wc[i], 32'(mcnt[i]));
    chk("busy_after", o_b[i], 0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1; tick(1); clr = 1'b0;
    mcnt[0] = 0; mcnt[1] = 0;
    tick(1);
  endtask

  initial begin
    rst_n = 1'b0; sclk = 0; mosi = 0; miso = 0; csn_a = 1; csn_b = 1;
    cpol = 0; cpha = 0; lsb_first = 0; detect_only = 0; clr = 0;
    for (int i = 0; i < 2; i++) begin
      nb[i] = 0; mcnt[i] = 0; accm[i] = '0; accs[i] = '0;
      last_m[i] = '0; last_s[i] = '0; last_pb[i] = '0;
    end
    tick(3);
    chk("reset_cnt_a", 32'(a_word_cnt), 0);
    chk("reset_busy_b", 32'(b_busy), 0);
    rst_n = 1'b1;
    tick(4);

    // Mode 0, MSB-first single byte.
    frame_begin(0, 0, 0, 0);
    send_word(0, 32'hA5, 32'h3C, 8, 0);
    frame_end(0);
    check_end(0);
    chk("t1_mosi", 32'(a_mosi_data), 32'hA5);
    chk("t1_miso", 32'(a_miso_data), 32'h3C);
    chk("t1_cnt", 32'(a_word_cnt), 1);

    // Mode 3, LSB-first, two bytes back to back.
    pulse_clr();
    cap_m[0].delete();
    frame_begin(0, 1, 1, 1);
    send_word(0, 32'h81, 32'h0F, 8, 0);
    send_word(0, 32'h7E, 32'hF0, 8, 0);
    frame_end(0);
    check_end(0);
    chk("t2_nwords", 32'(cap_m[0].size()), 2);
    if (cap_m[0].size() >= 2) begin
      chk("t2_first", cap_m[0][0], 32'h81);
      chk("t2_second", cap_m[0][1], 32'h7E);
    end
    chk("t2_miso", 32'(a_miso_data), 32'hF0);
    chk("t2_cnt", 32'(a_word_cnt), 2);

    // 12-bit words, mode 1, one word plus 5 trailing bits.
    frame_begin(1, 0, 1, 0);
    send_word(1, 32'hABC, 32'h123, 12, 0);
    send_word(1, 32'h16, 32'h09, 5, 0);
    frame_end(1);
    check_end(1);
    chk("t3_mosi", 32'(b_mosi_data), 32'hABC);
    chk("t3_miso", 32'(b_miso_data), 32'h123);
    chk("t3_pbits", 32'(b_partial_bits), 5);
    chk("t3_cnt", 32'(b_word_cnt), 1);

    // detect_only suppresses data but not detection or counting.
    pulse_clr();
    frame_begin(0, 0, 0, 0);
    send_word(0, 32'h11, 32'h22, 8, 0);
    frame_end(0);
    detect_only = 1'b1;
    frame_begin(0, 1, 0, 0);
    send_word(0, 32'h55, 32'hAA, 8, 0);
    frame_end(0);
    detect_only = 1'b0;
    check_end(0);
    chk("t4_mosi", 32'(a_mosi_data), 32'h11);
    chk("t4_miso", 32'(a_miso_data), 32'h22);
    chk("t4_cnt", 32'(a_word_cnt), 2);

    // Counter saturation, then clr coinciding with a completion.
    pulse_clr();
    frame_begin(0, 0, 0, 1);
    for (int w = 0; w < 17; w++) send_word(0, 32'(w * 13 + 1), 32'(255 - w), 8, 0);
    frame_end(0);
    check_end(0);
    chk("t5_sat", 32'(a_word_cnt), 15);
    frame_begin(0, 0, 0, 0);
    send_word(0, 32'h96, 32'h69, 8, 1);
    frame_end(0);
    check_end(0);
    chk("t5_clr_wins", 32'(a_word_cnt), 0);
    chk("t5_mosi", 32'(a_mosi_data), 32'h96);

    // Reset after 4 bits of a frame, then a clean frame.
    frame_begin(0, 0, 0, 0);
    send_word(0, 32'hA, 32'h5, 4, 0);
    tick(2);
    rst_n = 1'b0;
    tick(1);
    chk("t6_busy", 32'(a_busy), 0);
    chk("t6_mosi", 32'(a_mosi_data), 0);
    chk("t6_partial", 32'(a_partial), 0);
    set_csn(0, 1'b1);
    nb[0] = 0; mcnt[0] = 0; mcnt[1] = 0;
    exp_q[0].delete(); exp_p[0].delete();
    tick(4);
    rst_n = 1'b1;
    tick(4);
    frame_begin(0, 0, 0, 0);
    send_word(0, 32'hC3, 32'h3C, 8, 0);
    frame_end(0);
    check_end(0);
    chk("t6_mosi_after", 32'(a_mosi_data), 32'hC3);
    chk("t6_cnt", 32'(a_word_cnt), 1);

    tick(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
